// File: rtl/riscv_pkg.sv
// Shared opcodes, memory access sizes and mask helpers for the EX3 load/store path.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    function automatic logic [7:0] size_mask(input mem_size_e size);
        case (size)
            MEM_B:   size_mask = 8'h01;
            MEM_H:   size_mask = 8'h03;
            MEM_W:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input mem_size_e size);
        case (size)
            MEM_B:   align_mask = 3'b000;
            MEM_H:   align_mask = 3'b001;
            MEM_W:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-enable, store-lane shift and misalignment detection for one access.
// RISCV_MISALIGN_TRAP_EN: flag misaligned accesses instead of forcing natural alignment.
module riscv_lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  mem_size_e         size_i,
    input  logic [2:0]        offset_i,
    input  logic [XLEN-1:0]   rs2_i,
    output logic [7:0]        be_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              misaligned_o
);

    logic [2:0] eff_off;

    always_comb begin
`ifdef RISCV_MISALIGN_TRAP_EN
        eff_off      = offset_i;
        misaligned_o = |(offset_i & align_mask(size_i));
`else
        eff_off      = offset_i & ~align_mask(size_i);
        misaligned_o = 1'b0;
`endif
        be_o    = size_mask(size_i) << eff_off;
        wdata_o = rs2_i << {eff_off, 3'b000};
    end

endmodule

// File: rtl/riscv_ex3_stage.sv
// EX3 pipeline stage: holds the EX2 op and issues aligned D-cache requests, stalling upstream until granted.
// RISCV_MISALIGN_TRAP_EN: report misaligned mem ops to EX4 instead of issuing them aligned.
module riscv_ex3_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int PCNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   ex2_pc,
    input  logic [31:0]       ex2_inst,
    input  logic [XLEN-1:0]   ex2_alu_result,
    input  logic [XLEN-1:0]   ex2_rs2_data,
    input  logic [4:0]        ex2_rd_addr,
    input  logic [2:0]        ex2_funct3,
    input  logic              ex2_valid,
    input  logic              ex3_flush,
    output logic              ex3_stall,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [7:0]        dmem_be,
    output logic [XLEN-1:0]   ex3_pc,
    output logic [31:0]       ex3_inst,
    output logic [XLEN-1:0]   ex3_result,
    output logic [4:0]        ex3_rd_addr,
    output logic [2:0]        ex3_funct3,
    output logic              ex3_is_load,
    output logic              ex3_misaligned,
    output logic              ex3_valid,
    output logic [PCNT_W-1:0] ex3_stall_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [XLEN-1:0]   pc_q, alu_q, rs2_q;
    logic [31:0]       inst_q;
    logic [4:0]        rd_q;
    logic [2:0]        funct3_q;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [0:0]        state_q, state_d;
    logic [PCNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic is_load, is_store, is_mem, misaligned, req, accept, load_en;

    riscv_lsu_align #(.XLEN(XLEN)) u_align (
        .size_i       (mem_size_e'(funct3_q[1:0])),
        .offset_i     (alu_q[2:0]),
        .rs2_i        (rs2_q),
        .be_o         (dmem_be),
        .wdata_o      (dmem_wdata),
        .misaligned_o (misaligned)
    );

    always_comb begin
        is_load  = (inst_q[6:0] == OPC_LOAD);
        is_store = (inst_q[6:0] == OPC_STORE);
        is_mem   = valid_q & (is_load | is_store);
        req      = is_mem & ~misaligned & ~ex3_flush & ~done_q;
        accept   = req & dmem_req_ready;
        load_en  = ~(req & ~dmem_req_ready);
    end

    // A flush never stalls, so the stage always reloads (and drops the killed op) on flush.
    always_comb begin
        valid_d     = valid_q;
        done_d      = done_q | accept;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        if (load_en) begin
            valid_d = ex2_valid & ~ex3_flush;
            done_d  = 1'b0;
        end
        case (state_q)
            ST_IDLE: if (req & ~dmem_req_ready) state_d = ST_WAIT;
            default: if (dmem_req_ready | ex3_flush) state_d = ST_IDLE;
        endcase
        if (~load_en && stall_cnt_q != {PCNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            done_q      <= done_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en) begin
            pc_q     <= ex2_pc;
            inst_q   <= ex2_inst;
            alu_q    <= ex2_alu_result;
            rs2_q    <= ex2_rs2_data;
            rd_q     <= ex2_rd_addr;
            funct3_q <= ex2_funct3;
        end
    end

    always_comb begin
        ex3_stall      = ~load_en;
        dmem_req_valid = req;
        dmem_we        = is_store;
        dmem_addr      = {alu_q[XLEN-1:3], 3'b000};
        ex3_pc         = pc_q;
        ex3_inst       = inst_q;
        ex3_result     = alu_q;
        ex3_rd_addr    = rd_q;
        ex3_funct3     = funct3_q;
        ex3_is_load    = valid_q & is_load;
        ex3_misaligned = is_mem & misaligned;
        ex3_valid      = valid_q & ~ex3_stall & ~ex3_flush;
        ex3_stall_cnt  = stall_cnt_q;
    end

endmodule

// File: tb/tb_riscv_ex3_stage.sv
// Scoreboard bench for riscv_ex3_stage: directed scenarios followed by randomized traffic.
module tb_riscv_ex3_stage;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] result;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        isMem;
        logic        isLoad;
        logic        we;
        logic        mis;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ex2_pc, ex2_alu_result, ex2_rs2_data;
    logic [31:0] ex2_inst;
    logic [4:0]  ex2_rd_addr;
    logic [2:0]  ex2_funct3;
    logic        ex2_valid, ex3_flush, dmem_req_ready;
    logic        ex3_stall, dmem_req_valid, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, ex3_pc, ex3_result;
    logic [7:0]  dmem_be;
    logic [31:0] ex3_inst, ex3_stall_cnt;
    logic [4:0]  ex3_rd_addr;
    logic [2:0]  ex3_funct3;
    logic        ex3_is_load, ex3_misaligned, ex3_valid;

    int          nCompared = 0;
    int          nMismatched = 0;
    exp_t        expQ[$];
    logic [31:0] expCnt = '0;
    logic [63:0] pcCounter = 64'h8000_0000;

    riscv_ex3_stage #(.XLEN(64), .PCNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex2_pc(ex2_pc), .ex2_inst(ex2_inst), .ex2_alu_result(ex2_alu_result),
        .ex2_rs2_data(ex2_rs2_data), .ex2_rd_addr(ex2_rd_addr), .ex2_funct3(ex2_funct3),
        .ex2_valid(ex2_valid), .ex3_flush(ex3_flush), .ex3_stall(ex3_stall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .ex3_pc(ex3_pc), .ex3_inst(ex3_inst), .ex3_result(ex3_result),
        .ex3_rd_addr(ex3_rd_addr), .ex3_funct3(ex3_funct3), .ex3_is_load(ex3_is_load),
        .ex3_misaligned(ex3_misaligned), .ex3_valid(ex3_valid), .ex3_stall_cnt(ex3_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference view of one op: sizes in bytes, offsets as plain integers.
    function automatic exp_t makeExp();
        exp_t e;
        int unsigned sizeBytes, off, beInt;
        e.pc     = ex2_pc;
        e.inst   = ex2_inst;
        e.result = ex2_alu_result;
        e.rd     = ex2_rd_addr;
        e.f3     = ex2_funct3;
        e.isLoad = (ex2_inst[6:0] == 7'b0000011);
        e.we     = (ex2_inst[6:0] == 7'b0100011);
        e.isMem  = e.isLoad || e.we;
        sizeBytes = 1 << ex2_funct3[1:0];
        off       = int'(ex2_alu_result[2:0]);
`ifdef RISCV_MISALIGN_TRAP_EN
        e.mis = e.isMem && ((off % sizeBytes) != 0);
`else
        e.mis = 1'b0;
        off   = off - (off % sizeBytes);
`endif
        beInt   = ((1 << sizeBytes) - 1) << off;
        e.be    = beInt[7:0];
        e.addr  = ex2_alu_result & ~64'h7;
        e.wdata = ex2_rs2_data << (8 * off);
        return e;
    endfunction

    // Monitor: compares the held op whenever EX3 presents it, then records the op EX3 will load.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            expCnt = '0;
        end else begin
            logic expStall;
            expStall = (expQ.size() > 0) && expQ[0].isMem && !expQ[0].mis
                       && !ex3_flush && !dmem_req_ready;
            checkOutput("stall", ex3_stall, expStall);
            checkOutput("stall_cnt", ex3_stall_cnt, expCnt);
            if (expQ.size() == 0) begin
                checkOutput("idle_valid", ex3_valid, 0);
                checkOutput("idle_req", dmem_req_valid, 0);
            end else if (ex3_flush) begin
                checkOutput("flush_valid", ex3_valid, 0);
                checkOutput("flush_req", dmem_req_valid, 0);
                void'(expQ.pop_front());
            end else begin
                exp_t e;
                e = expQ[0];
                checkOutput("valid", ex3_valid, !expStall);
                checkOutput("req", dmem_req_valid, e.isMem && !e.mis);
                if (e.isMem && !e.mis) begin
                    checkOutput("addr", dmem_addr, e.addr);
                    checkOutput("we", dmem_we, e.we);
                    checkOutput("be", dmem_be, e.be);
                    if (e.we) checkOutput("wdata", dmem_wdata, e.wdata);
                end
                if (!expStall) begin
                    checkOutput("result", ex3_result, e.result);
                    checkOutput("pc", ex3_pc, e.pc);
                    checkOutput("inst", ex3_inst, e.inst);
                    checkOutput("rd", ex3_rd_addr, e.rd);
                    checkOutput("funct3", ex3_funct3, e.f3);
                    checkOutput("is_load", ex3_is_load, e.isLoad);
                    checkOutput("misaligned", ex3_misaligned, e.mis);
                    void'(expQ.pop_front());
                end
            end
            if (expStall && expCnt != 32'hFFFF_FFFF) expCnt = expCnt + 1;
            if (!expStall && ex2_valid && !ex3_flush) expQ.push_back(makeExp());
        end
    end

    task automatic applyStimulus(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [63:0] alu, input logic [63:0] rs2,
                                 input logic [4:0] rd, input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        pcCounter      = pcCounter + 64'd4;
        ex2_valid      = v;
        ex2_pc         = pcCounter;
        ex2_inst       = {12'h0, 5'd1, f3, rd, opc};
        ex2_funct3     = f3;
        ex2_alu_result = alu;
        ex2_rs2_data   = rs2;
        ex2_rd_addr    = rd;
        dmem_req_ready = rdy;
        ex3_flush      = fl;
    endtask

    task automatic bubble(input logic rdy);
        applyStimulus(1'b0, 7'b0010011, 3'd0, 64'h0, 64'h0, 5'd0, rdy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        ex2_valid = 1'b0; ex3_flush = 1'b0; dmem_req_ready = 1'b1;
        ex2_pc = '0; ex2_inst = '0; ex2_alu_result = '0; ex2_rs2_data = '0;
        ex2_rd_addr = '0; ex2_funct3 = '0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_valid", ex3_valid, 0);
        checkOutput("rst_stall", ex3_stall, 0);
        checkOutput("rst_req", dmem_req_valid, 0);
        checkOutput("rst_mis", ex3_misaligned, 0);
        checkOutput("rst_cnt", ex3_stall_cnt, 0);
        rst_n = 1'b1;

        $display("[TB] ALU pass-through");
        applyStimulus(1'b1, 7'b0110011, 3'd0, 64'h2A, 64'h0, 5'd5, 1'b1, 1'b0);
        bubble(1'b1); #1;
        checkOutput("alu_valid", ex3_valid, 1);
        checkOutput("alu_result", ex3_result, 64'h2A);
        checkOutput("alu_req", dmem_req_valid, 0);

        $display("[TB] SW lane shift");
        applyStimulus(1'b1, 7'b0100011, 3'd2, 64'h1004, 64'hDEADBEEF, 5'd0, 1'b1, 1'b0);
        bubble(1'b1); #1;
        checkOutput("sw_be", dmem_be, 8'hF0);
        checkOutput("sw_wdata", dmem_wdata, 64'hDEADBEEF_00000000);
        checkOutput("sw_addr", dmem_addr, 64'h1000);
        checkOutput("sw_we", dmem_we, 1);
        checkOutput("sw_stall", ex3_stall, 0);

        $display("[TB] LD held for three cycles");
        applyStimulus(1'b1, 7'b0000011, 3'd3, 64'h2000, 64'h0, 5'd7, 1'b0, 1'b0);
        bubble(1'b0); bubble(1'b0); bubble(1'b0);
        bubble(1'b1); #1;
        checkOutput("ld_cnt", ex3_stall_cnt, 3);
        checkOutput("ld_valid", ex3_valid, 1);
        checkOutput("ld_stall", ex3_stall, 0);

        $display("[TB] SH at odd address");
        applyStimulus(1'b1, 7'b0100011, 3'd1, 64'h3001, 64'hBEEF, 5'd0, 1'b1, 1'b0);
        bubble(1'b1); #1;
`ifdef RISCV_MISALIGN_TRAP_EN
        checkOutput("sh_req", dmem_req_valid, 0);
        checkOutput("sh_valid", ex3_valid, 1);
        checkOutput("sh_mis", ex3_misaligned, 1);
`else
        checkOutput("sh_be", dmem_be, 8'h03);
        checkOutput("sh_addr", dmem_addr, 64'h3000);
        checkOutput("sh_req", dmem_req_valid, 1);
`endif

        $display("[TB] LW flushed while waiting");
        applyStimulus(1'b1, 7'b0000011, 3'd2, 64'h4000, 64'h0, 5'd9, 1'b0, 1'b0);
        bubble(1'b0); #1;
        checkOutput("lw_stall", ex3_stall, 1);
        #1; ex3_flush = 1'b1; #1;
        checkOutput("lw_flush_req", dmem_req_valid, 0);
        checkOutput("lw_flush_stall", ex3_stall, 0);
        bubble(1'b1); #1;
        checkOutput("lw_flush_valid", ex3_valid, 0);

        $display("[TB] reset while waiting");
        applyStimulus(1'b1, 7'b0000011, 3'd3, 64'h5000, 64'h0, 5'd3, 1'b0, 1'b0);
        bubble(1'b0); #1;
        checkOutput("rw_stall", ex3_stall, 1);
        rst_n = 1'b0; #1;
        checkOutput("rw_req", dmem_req_valid, 0);
        checkOutput("rw_stall0", ex3_stall, 0);
        checkOutput("rw_valid", ex3_valid, 0);
        checkOutput("rw_cnt", ex3_stall_cnt, 0);
        bubble(1'b1); bubble(1'b1);
        rst_n = 1'b1;
        applyStimulus(1'b1, 7'b0000011, 3'd3, 64'h6000, 64'h0, 5'd4, 1'b1, 1'b0);
        bubble(1'b1); #1;
        checkOutput("post_rst_req", dmem_req_valid, 1);
        checkOutput("post_rst_addr", dmem_addr, 64'h6000);
        checkOutput("post_rst_valid", ex3_valid, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            logic [6:0]  opc;
            logic [2:0]  f3;
            logic [63:0] alu, rs2;
            int unsigned kind;
            kind = $urandom_range(0, 2);
            opc  = (kind == 0) ? 7'b0110011 : (kind == 1) ? 7'b0000011 : 7'b0100011;
            f3   = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            alu  = {$urandom(), $urandom()};
            rs2  = {$urandom(), $urandom()};
            applyStimulus($urandom_range(0, 9) < 7, opc, f3, alu, rs2, 5'($urandom()),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        repeat (4) bubble(1'b1);
        #1;
        checkOutput("drain_empty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
